// File: rtl/hdlc_bus_sequencer.sv
// Shares the Hdlc address/data register bus between a TX byte source and an RX byte sink.
// Define HDLC_SEQ_ABORT_EN to add the tx_abort input (Tx_AbortFrame writes to Tx_SC).
module hdlc_bus_sequencer #(
    parameter int unsigned MAX_TX_BYTES = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
`ifdef HDLC_SEQ_ABORT_EN
    input  logic       tx_abort,
`endif
    output logic       tx_ready,
    output logic       tx_trunc,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_last,
    input  logic       rx_ready,
    output logic       rx_err_valid,
    output logic [3:0] rx_err,
    input  logic       cfg_fcs_en,
    output logic       busy,
    output logic [2:0] hdlc_Address,
    output logic       hdlc_WriteEnable,
    output logic       hdlc_ReadEnable,
    output logic [7:0] hdlc_DataIn,
    input  logic [7:0] hdlc_DataOut,
    input  logic       hdlc_Rx_Ready,
    input  logic       hdlc_Tx_Done
);

    localparam int unsigned CW = 8;
    localparam logic [2:0] A_TX_SC   = 3'd0;
    localparam logic [2:0] A_TX_BUFF = 3'd1;
    localparam logic [2:0] A_RX_SC   = 3'd2;
    localparam logic [2:0] A_RX_BUFF = 3'd3;
    localparam logic [2:0] A_RX_LEN  = 3'd4;

    typedef enum logic [3:0] {
        INIT, IDLE, TX_LOAD, TX_FLUSH, TX_GO,
        RX_SC, RX_SC_W, RX_LEN, RX_LEN_W, RX_RD, RX_RD_W, RX_OUT, RX_DROP
    } state_t;

    state_t        state;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_len;
    logic [CW-1:0] rx_idx;
    logic          rx_pref;
    logic          fcs_q;
    logic          flush_go;
`ifdef HDLC_SEQ_ABORT_EN
    logic          abort_sent;
`endif

    logic rx_elig;
    logic tx_elig;
    assign rx_elig = hdlc_Rx_Ready;
    assign tx_elig = tx_valid && hdlc_Tx_Done;

    // busy is registered from the current state, so it trails state changes by one cycle
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state            <= INIT;
            tx_ready         <= 1'b0;
            tx_trunc         <= 1'b0;
            rx_valid         <= 1'b0;
            rx_data          <= 8'h00;
            rx_last          <= 1'b0;
            rx_err_valid     <= 1'b0;
            rx_err           <= 4'h0;
            busy             <= 1'b0;
            hdlc_Address     <= 3'd0;
            hdlc_WriteEnable <= 1'b0;
            hdlc_ReadEnable  <= 1'b0;
            hdlc_DataIn      <= 8'h00;
            tx_cnt           <= '0;
            rx_len           <= '0;
            rx_idx           <= '0;
            rx_pref          <= 1'b1;
            fcs_q            <= 1'b0;
            flush_go         <= 1'b0;
`ifdef HDLC_SEQ_ABORT_EN
            abort_sent       <= 1'b0;
`endif
        end else begin
            hdlc_WriteEnable <= 1'b0;
            hdlc_ReadEnable  <= 1'b0;
            tx_trunc         <= 1'b0;
            rx_err_valid     <= 1'b0;
            busy             <= (state != IDLE);
`ifdef HDLC_SEQ_ABORT_EN
            if (!tx_abort) abort_sent <= 1'b0;
`endif
            unique case (state)
                INIT: begin
                    hdlc_WriteEnable <= 1'b1;
                    hdlc_Address     <= A_RX_SC;
                    hdlc_DataIn      <= {2'b00, cfg_fcs_en, 5'b00000};
                    fcs_q            <= cfg_fcs_en;
                    state            <= IDLE;
                end
                IDLE: begin
                    if (cfg_fcs_en != fcs_q) begin
                        state <= INIT;
                    end else if (hdlc_WriteEnable || hdlc_ReadEnable) begin
                        // wait one cycle so Hdlc status reflects our own last access
                    end
`ifdef HDLC_SEQ_ABORT_EN
                    else if (tx_abort && !hdlc_Tx_Done && !abort_sent) begin
                        hdlc_WriteEnable <= 1'b1;
                        hdlc_Address     <= A_TX_SC;
                        hdlc_DataIn      <= 8'h04;
                        abort_sent       <= 1'b1;
                    end
`endif
                    else if (rx_elig && (rx_pref || !tx_elig)) begin
                        hdlc_ReadEnable <= 1'b1;
                        hdlc_Address    <= A_RX_SC;
                        rx_pref         <= 1'b0;
                        state           <= RX_SC;
                    end else if (tx_elig) begin
                        tx_ready <= 1'b1;
                        tx_cnt   <= '0;
                        rx_pref  <= 1'b1;
                        state    <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
`ifdef HDLC_SEQ_ABORT_EN
                    if (tx_abort) begin
                        hdlc_WriteEnable <= 1'b1;
                        hdlc_Address     <= A_TX_SC;
                        hdlc_DataIn      <= 8'h04;
                        flush_go         <= 1'b0;
                        if (tx_valid && tx_last) begin
                            tx_ready <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= TX_FLUSH;
                        end
                    end else
`endif
                    if (tx_valid) begin
                        hdlc_WriteEnable <= 1'b1;
                        hdlc_Address     <= A_TX_BUFF;
                        hdlc_DataIn      <= tx_data;
                        tx_cnt           <= tx_cnt + 8'd1;
                        if (tx_last) begin
                            tx_ready <= 1'b0;
                            state    <= TX_GO;
                        end else if (tx_cnt == CW'(MAX_TX_BYTES - 1)) begin
                            tx_trunc <= 1'b1;
                            flush_go <= 1'b1;
                            state    <= TX_FLUSH;
                        end
                    end
                end
                TX_FLUSH: begin
                    if (tx_valid && tx_last) begin
                        tx_ready <= 1'b0;
                        state    <= flush_go ? TX_GO : IDLE;
                    end
                end
                TX_GO: begin
                    hdlc_WriteEnable <= 1'b1;
                    hdlc_Address     <= A_TX_SC;
`ifdef HDLC_SEQ_ABORT_EN
                    hdlc_DataIn      <= tx_abort ? 8'h04 : 8'h02;
`else
                    hdlc_DataIn      <= 8'h02;
`endif
                    state            <= IDLE;
                end
                RX_SC:  state <= RX_SC_W;
                RX_SC_W: begin
                    if (hdlc_DataOut[4:1] != 4'h0) begin
                        rx_err <= hdlc_DataOut[4:1];
                        state  <= RX_DROP;
                    end else begin
                        hdlc_ReadEnable <= 1'b1;
                        hdlc_Address    <= A_RX_LEN;
                        state           <= RX_LEN;
                    end
                end
                RX_LEN: state <= RX_LEN_W;
                RX_LEN_W: begin
                    rx_len <= hdlc_DataOut;
                    if (hdlc_DataOut == 8'h00) begin
                        rx_err <= 4'b0001;
                        state  <= RX_DROP;
                    end else begin
                        hdlc_ReadEnable <= 1'b1;
                        hdlc_Address    <= A_RX_BUFF;
                        rx_idx          <= '0;
                        state           <= RX_RD;
                    end
                end
                RX_RD:  state <= RX_RD_W;
                RX_RD_W: begin
                    rx_data  <= hdlc_DataOut;
                    rx_valid <= 1'b1;
                    rx_last  <= (rx_idx + 8'd1 == rx_len);
                    rx_idx   <= rx_idx + 8'd1;
                    state    <= RX_OUT;
                end
                RX_OUT: begin
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        rx_last  <= 1'b0;
                        if (rx_last) begin
                            state <= IDLE;
                        end else begin
                            hdlc_ReadEnable <= 1'b1;
                            hdlc_Address    <= A_RX_BUFF;
                            state           <= RX_RD;
                        end
                    end
                end
                RX_DROP: begin
                    hdlc_WriteEnable <= 1'b1;
                    hdlc_Address     <= A_RX_SC;
                    hdlc_DataIn      <= {2'b00, cfg_fcs_en, 4'b0000, 1'b1};
                    rx_err_valid     <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
